nabp_angle_scheduler: RTL



---
 rtl/nabp_sched_pkg.sv | 29 ++
 rtl/nabp_angle_scheduler_if.sv | 50 +++++
 rtl/nabp_angle_mod_step.sv | 31 +++
 rtl/nabp_angle_scheduler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/nabp_sched_pkg.sv
// ============================================================================
//  Module   : nabp_sched_pkg
//  Purpose  : Shared state encoding and default widths for the angle scheduler.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package nabp_sched_pkg;

    // c_ANGLE_LENGTH mirrors kAngleLength used by the rest of the NABP datapath.
    localparam int c_ANGLE_LENGTH    = 8;
    localparam int c_ANGLE_MODULUS   = 180;
    localparam int c_COUNT_LENGTH    = 8;
    localparam int c_MAX_OUTSTANDING = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    function automatic int outstanding_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nabp_angle_scheduler_if.sv
// ============================================================================
//  Module   : nabp_angle_scheduler_if
//  Purpose  : Control, next-angle and release handshakes of the angle scheduler.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface nabp_angle_scheduler_if
    import nabp_sched_pkg::*;
#(
    parameter int ANGLE_LENGTH    = c_ANGLE_LENGTH,
    parameter int COUNT_LENGTH    = c_COUNT_LENGTH,
    parameter int MAX_OUTSTANDING = c_MAX_OUTSTANDING
) ();

    localparam int OUT_W = outstanding_width(MAX_OUTSTANDING);

    logic                    start;
    logic [ANGLE_LENGTH-1:0] cfg_angle_start;
    logic [ANGLE_LENGTH-1:0] cfg_angle_step;
    logic [COUNT_LENGTH-1:0] cfg_angle_count;
    logic                    next_angle;
    logic                    next_angle_ack;
    logic [ANGLE_LENGTH-1:0] angle;
    logic                    has_next_angle;
    logic                    prev_angle_release;
    logic                    prev_angle_release_ack;
    logic [OUT_W-1:0]        outstanding;
    logic                    busy;
    logic                    done;
    logic                    err_release;

    // Master is the swap control side; slave is the scheduler.
    modport master (
        output start, cfg_angle_start, cfg_angle_step, cfg_angle_count,
        output next_angle, prev_angle_release,
        input  next_angle_ack, angle, has_next_angle, prev_angle_release_ack,
        input  outstanding, busy, done, err_release
    );

    modport slave (
        input  start, cfg_angle_start, cfg_angle_step, cfg_angle_count,
        input  next_angle, prev_angle_release,
        output next_angle_ack, angle, has_next_angle, prev_angle_release_ack,
        output outstanding, busy, done, err_release
    );

endinterface

`default_nettype wire

// File: rtl/nabp_angle_mod_step.sv
// ============================================================================
//  Module   : nabp_angle_mod_step
//  Purpose  : Combinational modulo adder: next = (angle + step) mod ANGLE_MODULUS.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nabp_angle_mod_step
    import nabp_sched_pkg::*;
#(
    parameter int ANGLE_LENGTH  = c_ANGLE_LENGTH,
    parameter int ANGLE_MODULUS = c_ANGLE_MODULUS
) (
    input  wire logic [ANGLE_LENGTH-1:0] angle,
    input  wire logic [ANGLE_LENGTH-1:0] step,
    output logic      [ANGLE_LENGTH-1:0] next_angle
);

    localparam logic [ANGLE_LENGTH:0] c_MODULUS = (ANGLE_LENGTH + 1)'(ANGLE_MODULUS);

    logic [ANGLE_LENGTH:0] w_sum;
    logic [ANGLE_LENGTH:0] w_result;

    // Carry bit is kept so sums past 2**ANGLE_LENGTH still compare correctly.
    assign w_sum    = {1'b0, angle} + {1'b0, step};
    assign w_result = (w_sum >= c_MODULUS) ? (w_sum - c_MODULUS) : w_sum;
    assign next_angle = ANGLE_LENGTH'(w_result);

endmodule

`default_nettype wire

// File: rtl/nabp_angle_scheduler.sv
// ============================================================================
//  Module   : nabp_angle_scheduler
//  Purpose  : Issues an arithmetic projection-angle sequence to swap control,
//             capping issued-but-unreleased angles. Optional statistics via
//             NABP_ANGLE_SCHED_STATS_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nabp_angle_scheduler
    import nabp_sched_pkg::*;
#(
    parameter int ANGLE_LENGTH    = c_ANGLE_LENGTH,
    parameter int ANGLE_MODULUS   = c_ANGLE_MODULUS,
    parameter int COUNT_LENGTH    = c_COUNT_LENGTH,
    parameter int MAX_OUTSTANDING = c_MAX_OUTSTANDING
) (
    input  wire logic              clk,
    input  wire logic              reset,
`ifdef NABP_ANGLE_SCHED_STATS_EN
    output logic      [31:0]       st_stall_cycles,
    output logic      [31:0]       st_busy_cycles,
`endif
    nabp_angle_scheduler_if.slave  bus
);

    localparam int              OUT_W     = outstanding_width(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0] c_MAX_OUT = OUT_W'(MAX_OUTSTANDING);

    sched_state_t            r_state;
    sched_state_t            w_state_next;
    logic [ANGLE_LENGTH-1:0] r_angle;
    logic [ANGLE_LENGTH-1:0] r_next_angle;
    logic [ANGLE_LENGTH-1:0] r_step;
    logic [ANGLE_LENGTH-1:0] w_stepped;
    logic [COUNT_LENGTH-1:0] r_remaining;
    logic [OUT_W-1:0]        r_outstanding;
    logic [OUT_W-1:0]        w_outstanding_next;
    logic                    r_next_ack;
    logic                    r_release_ack;
    logic                    r_done;
    logic                    r_err_release;
    logic                    w_start_accept;
    logic                    w_grant;
    logic                    w_release_req;
    logic                    w_release;
    logic                    w_release_err;

    nabp_angle_mod_step #(
        .ANGLE_LENGTH  (ANGLE_LENGTH),
        .ANGLE_MODULUS (ANGLE_MODULUS)
    ) u_mod_step (
        .angle      (r_next_angle),
        .step       (r_step),
        .next_angle (w_stepped)
    );

    assign w_start_accept = (r_state == ST_IDLE) && bus.start;

    // The registered ack masks the request for one cycle: the requester still
    // holds it on the edge after the ack and must not be served twice.
    assign w_grant = (r_state == ST_ISSUE) && (r_remaining != '0) &&
                     bus.next_angle && !r_next_ack && (r_outstanding < c_MAX_OUT);

    assign w_release_req = (r_state != ST_DONE) && bus.prev_angle_release && !r_release_ack;
    assign w_release     = w_release_req && (r_outstanding != '0);
    assign w_release_err = w_release_req && (r_outstanding == '0);

    always_comb begin
        w_outstanding_next = r_outstanding;
        case ({w_grant, w_release})
            2'b10:   w_outstanding_next = r_outstanding + OUT_W'(1);
            2'b01:   w_outstanding_next = r_outstanding - OUT_W'(1);
            default: w_outstanding_next = r_outstanding;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.cfg_angle_count != '0) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                if (r_remaining == '0) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Look at the post-release count so done trails the last release by one cycle.
                if (w_outstanding_next == '0) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_angle       <= '0;
            r_next_angle  <= '0;
            r_step        <= '0;
            r_remaining   <= '0;
            r_outstanding <= '0;
            r_next_ack    <= 1'b0;
            r_release_ack <= 1'b0;
            r_done        <= 1'b0;
            r_err_release <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_outstanding_next;
            r_next_ack    <= w_grant;
            r_release_ack <= w_release;
            r_done        <= (r_state == ST_DONE);

            if (w_start_accept) begin
                r_angle      <= bus.cfg_angle_start;
                r_next_angle <= bus.cfg_angle_start;
                r_step       <= bus.cfg_angle_step;
                r_remaining  <= bus.cfg_angle_count;
            end else if (w_grant) begin
                r_angle      <= r_next_angle;
                r_next_angle <= w_stepped;
                r_remaining  <= r_remaining - COUNT_LENGTH'(1);
            end

            if (w_start_accept) begin
                r_err_release <= 1'b0;
            end else if (w_release_err) begin
                r_err_release <= 1'b1;
            end
        end
    end

`ifdef NABP_ANGLE_SCHED_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_busy_cycles;
    logic        w_stall;

    assign w_stall = (r_state == ST_ISSUE) && (r_remaining != '0) &&
                     bus.next_angle && (r_outstanding == c_MAX_OUT);

    always_ff @(posedge clk) begin
        if (reset || w_start_accept) begin
            r_stall_cycles <= '0;
            r_busy_cycles  <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if ((r_state != ST_IDLE) && (r_busy_cycles != '1)) begin
                r_busy_cycles <= r_busy_cycles + 32'd1;
            end
        end
    end

    assign st_stall_cycles = r_stall_cycles;
    assign st_busy_cycles  = r_busy_cycles;
`endif

    assign bus.next_angle_ack         = r_next_ack;
    assign bus.angle                  = r_angle;
    assign bus.has_next_angle         = (r_state == ST_ISSUE) && (r_remaining != '0);
    assign bus.prev_angle_release_ack = r_release_ack;
    assign bus.outstanding            = r_outstanding;
    assign bus.busy                   = (r_state != ST_IDLE);
    assign bus.done                   = r_done;
    assign bus.err_release            = r_err_release;

endmodule

`default_nettype wire
